// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared definitions for the memory-mapped UART transmitter.
//   - txState_e      : engine states (PARITY only exists with UART_TX_PARITY_EN)
//   - REG_*          : register word offsets (CPU address bits [3:2])
//   - STAT_*         : bit positions inside the STATUS word
//   - MIN_DIVIDER    : smallest clocks-per-bit the engine will use
//   - effDivider()   : clamps a programmed divider to MIN_DIVIDER
// Optional feature macro: UART_TX_PARITY_EN
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } txState_e;

  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_DIVIDER = 2'd2;

  localparam int STAT_BUSY      = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_EMPTY     = 2;
  localparam int STAT_OVERFLOW  = 3;
  localparam int STAT_COUNT_LSB = 8;
  localparam int STAT_COUNT_MSB = 16;

  localparam logic [15:0] MIN_DIVIDER = 16'd2;

  // A divider of 0 or 1 would make a bit period too short for the
  // down-counter to express, so such values behave as MIN_DIVIDER.
  function automatic logic [15:0] effDivider(input logic [15:0] raw);
    return (raw < MIN_DIVIDER) ? MIN_DIVIDER : raw;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: circular FIFO with pointers one bit wider than the address,
// so that full and empty are distinguishable. No bus knowledge.
// Ports:
//   clock, reset       : clock, asynchronous active-high reset
//   push_i, pushData_i : enqueue request and byte (ignored while full)
//   pop_i, popData_o   : dequeue request (ignored while empty), head byte
//   full_o, empty_o    : occupancy flags from current (pre-edge) state
//   count_o            : number of stored entries, 0..DEPTH
module uart_tx_fifo
  import uart_tx_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           pushData_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           popData_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wrPtr_q, rdPtr_q;
  logic             pushOk, popOk;

  assign empty_o   = (wrPtr_q == rdPtr_q);
  assign full_o    = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign count_o   = wrPtr_q - rdPtr_q;
  assign popData_o = mem[rdPtr_q[AW-1:0]];

  // Flags come from pre-edge state: a push on a full FIFO is dropped even
  // when a pop happens in the same cycle.
  assign pushOk = push_i && !full_o;
  assign popOk  = pop_i && !empty_o;

  // Pointers wrap naturally modulo 2*DEPTH.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      if (pushOk) wrPtr_q <= wrPtr_q + 1'b1;
      if (popOk)  rdPtr_q <= rdPtr_q + 1'b1;
    end
  end

  // Storage carries no reset; only pointer-covered entries are ever read.
  always_ff @(posedge clock) begin
    if (pushOk) mem[wrPtr_q[AW-1:0]] <= pushData_i;
  end

endmodule

// File: rtl/uart_tx_peripheral.sv
// uart_tx_peripheral: memory-mapped UART transmitter for the 0xff I/O region.
// Ports:
//   clock, reset        : clock, asynchronous active-high reset
//   cs, read, write     : chip select and bus strobes
//   address[1:0]        : word select (0 DATA, 1 STATUS, 2 DIVIDER, 3 unused)
//   data_in[31:0]       : write data; data_strobes[3:0] byte lanes
//   data_out[31:0]      : registered read data, held until the next read
//   tx                  : serial line, idle high
//   irq                 : high while the FIFO is empty and the engine idle
// Optional feature macro: UART_TX_PARITY_EN (DIVIDER bit16 enable, bit17 odd).
module uart_tx_peripheral
  import uart_tx_pkg::*;
#(
  parameter int FIFO_DEPTH      = 16,
  parameter int DEFAULT_DIVIDER = 434
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cs,
  input  logic        read,
  input  logic        write,
  input  logic [1:0]  address,
  input  logic [31:0] data_in,
  input  logic [3:0]  data_strobes,
  output logic [31:0] data_out,
  output logic        tx,
  output logic        irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
`ifdef UART_TX_PARITY_EN
  localparam int DIVW = 18;
`else
  localparam int DIVW = 16;
`endif

  txState_e         state_q, state_d;
  logic [15:0]      bitCnt_q, bitCnt_d, reloadVal;
  logic [2:0]       bitIdx_q, bitIdx_d;
  logic [7:0]       shift_q, shift_d;
  logic [DIVW-1:0]  divider_q, divider_d;
  logic             overflow_q, overflow_d;
  logic [31:0]      dataOut_q, readData, statusWord;
  logic             tx_q, tx_d, irq_q;
  logic             parBit_q, parBit_d, parEn_q, parEn_d;

  logic             busWr, busRd, pushReq, statusRd, pop, tick;
  logic             fifoFull, fifoEmpty;
  logic [7:0]       fifoData;
  logic [CW-1:0]    fifoCount;
  logic             unusedBits;

  assign busWr    = cs && write;
  assign busRd    = cs && read;
  assign pushReq  = busWr && (address == REG_DATA) && data_strobes[0];
  assign statusRd = busRd && (address == REG_STATUS);

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) uFifo (
    .clock      (clock),
    .reset      (reset),
    .push_i     (pushReq),
    .pushData_i (data_in[7:0]),
    .pop_i      (pop),
    .popData_o  (fifoData),
    .full_o     (fifoFull),
    .empty_o    (fifoEmpty),
    .count_o    (fifoCount)
  );

  // Register-side next state: byte-lane divider writes and sticky overflow.
  // A dropped push wins over the clearing STATUS read.
  always_comb begin
    divider_d = divider_q;
    if (busWr && (address == REG_DIVIDER)) begin
      if (data_strobes[0]) divider_d[7:0]  = data_in[7:0];
      if (data_strobes[1]) divider_d[15:8] = data_in[15:8];
`ifdef UART_TX_PARITY_EN
      if (data_strobes[2]) divider_d[17:16] = data_in[17:16];
`endif
    end
    overflow_d = overflow_q;
    if (pushReq && fifoFull) overflow_d = 1'b1;
    else if (statusRd)       overflow_d = 1'b0;
  end

  // STATUS word and read mux, all from pre-edge state.
  always_comb begin
    statusWord                               = '0;
    statusWord[STAT_BUSY]                    = (state_q != IDLE);
    statusWord[STAT_FULL]                    = fifoFull;
    statusWord[STAT_EMPTY]                   = fifoEmpty;
    statusWord[STAT_OVERFLOW]                = overflow_q;
    statusWord[STAT_COUNT_MSB:STAT_COUNT_LSB] = 9'(fifoCount);
    case (address)
      REG_STATUS:  readData = statusWord;
      REG_DIVIDER: readData = 32'(divider_q);
      default:     readData = '0;
    endcase
  end

  // Engine next state. The bit counter runs from divider-1 down to 0 and the
  // engine advances on 0; tx is registered from the next state so it is
  // glitch-free and changes exactly at bit boundaries.
  always_comb begin
    state_d   = state_q;
    bitCnt_d  = bitCnt_q;
    bitIdx_d  = bitIdx_q;
    shift_d   = shift_q;
    parBit_d  = parBit_q;
    parEn_d   = parEn_q;
    pop       = 1'b0;
    reloadVal = effDivider(divider_q[15:0]) - 16'd1;
    tick      = (bitCnt_q == 16'd0);
    case (state_q)
      IDLE: begin
        if (!fifoEmpty) begin
          pop      = 1'b1;
          shift_d  = fifoData;
          bitCnt_d = reloadVal;
          state_d  = START;
`ifdef UART_TX_PARITY_EN
          parEn_d  = divider_q[16];
          parBit_d = (^fifoData) ^ divider_q[17];
`endif
        end
      end
      START: begin
        if (tick) begin
          state_d  = DATA;
          bitCnt_d = reloadVal;
          bitIdx_d = 3'd0;
        end else bitCnt_d = bitCnt_q - 16'd1;
      end
      DATA: begin
        if (tick) begin
          bitCnt_d = reloadVal;
          shift_d  = shift_q >> 1;
          bitIdx_d = bitIdx_q + 3'd1;
          if (bitIdx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = parEn_q ? PARITY : STOP;
`else
            state_d = STOP;
`endif
          end
        end else bitCnt_d = bitCnt_q - 16'd1;
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          state_d  = STOP;
          bitCnt_d = reloadVal;
        end else bitCnt_d = bitCnt_q - 16'd1;
      end
`endif
      STOP: begin
        if (tick) state_d = IDLE;
        else      bitCnt_d = bitCnt_q - 16'd1;
      end
      default: state_d = IDLE;
    endcase
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = parBit_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  // All state registers; reset abandons any frame in progress at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      bitCnt_q   <= '0;
      bitIdx_q   <= '0;
      shift_q    <= '0;
      parBit_q   <= 1'b0;
      parEn_q    <= 1'b0;
      divider_q  <= DIVW'(DEFAULT_DIVIDER);
      overflow_q <= 1'b0;
      dataOut_q  <= '0;
      tx_q       <= 1'b1;
      irq_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      bitCnt_q   <= bitCnt_d;
      bitIdx_q   <= bitIdx_d;
      shift_q    <= shift_d;
      parBit_q   <= parBit_d;
      parEn_q    <= parEn_d;
      divider_q  <= divider_d;
      overflow_q <= overflow_d;
      tx_q       <= tx_d;
      irq_q      <= fifoEmpty && (state_q == IDLE);
      if (busRd) dataOut_q <= readData;
    end
  end

  assign data_out = dataOut_q;
  assign tx       = tx_q;
  assign irq      = irq_q;

  // Parity state/bit are constant without the feature; upper lanes unused.
  assign unusedBits = ^{data_in[31:16], data_strobes[3:2], parBit_q, parEn_q};

endmodule
